// File: rtl/burst_word_serializer.sv
// burst_word_serializer
// Streams one 128-bit lc3b_burst line out as eight 16-bit lc3b_words over a
// valid/ready beat interface. A single-word mode emits just the selected word.
//
// Optional build macro: BURST_SERIALIZER_CRITICAL_FIRST_EN
//   defined   : an 8-beat burst starts at word offset[3:1] and wraps around the line
//   undefined : an 8-beat burst always runs words 0..7; single mode still emits
//               word offset[3:1]
//
// Beat data is muxed only from registered state, so word_out, word_valid,
// word_index, last and busy have no combinational path from any input.
// load_ready is combinational on abort/word_ready so a new line can be taken
// on the same edge that retires the last beat, giving back-to-back bursts.

module burst_word_serializer #(
  parameter int WORDS  = 8,   // words per line, must equal 128 / WORD_W
  parameter int WORD_W = 16   // bits per emitted word
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [127:0]      line_in,
  input  logic [3:0]        offset,
  input  logic              single,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              abort,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [2:0]        word_index,
  output logic              last,
  output logic              busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t       state_q;
  logic [127:0] line_q;
  logic [2:0]   idx_q;
  logic [2:0]   count_q;
  logic         single_q;

  logic [2:0]   start_idx;
  logic         beat_fire;
  logic         load_fire;
  logic         is_last;

  // offset[0] addresses a byte within a word and has no meaning here.
  logic         unused_offset_lsb;
  assign unused_offset_lsb = offset[0];

  // Pick the first word of a new burst. Single mode always needs the
  // addressed word; full bursts only honour it with critical-word-first.
`ifdef BURST_SERIALIZER_CRITICAL_FIRST_EN
  assign start_idx = offset[3:1];
`else
  assign start_idx = single ? offset[3:1] : 3'd0;
`endif

  // Handshake qualifiers and the final-beat flag, all from registered state
  // except for the incoming handshake inputs themselves.
  always_comb begin
    is_last    = 1'b0;
    beat_fire  = 1'b0;
    load_ready = 1'b0;
    load_fire  = 1'b0;
    if (state_q == STREAM) begin
      is_last = (single_q && (count_q == 3'd0)) || (count_q == 3'(WORDS - 1));
    end
    beat_fire  = (state_q == STREAM) && word_ready;
    load_ready = !abort && ((state_q == IDLE) || (beat_fire && is_last));
    load_fire  = load_valid && load_ready;
  end

  // Beat outputs: idle drives zeros, streaming muxes the current word.
  always_comb begin
    word_out   = '0;
    word_valid = 1'b0;
    word_index = 3'd0;
    last       = 1'b0;
    busy       = 1'b0;
    if (state_q == STREAM) begin
      word_out   = line_q[int'(idx_q) * WORD_W +: WORD_W];
      word_valid = 1'b1;
      word_index = idx_q;
      last       = is_last;
      busy       = 1'b1;
    end
  end

  // Burst FSM: abort beats everything, then load (possibly chained onto the
  // last beat), then ordinary beat advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      line_q   <= '0;
      idx_q    <= 3'd0;
      count_q  <= 3'd0;
      single_q <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
    end else if (load_fire) begin
      state_q  <= STREAM;
      line_q   <= line_in;
      idx_q    <= start_idx;
      count_q  <= 3'd0;
      single_q <= single;
    end else if (beat_fire) begin
      idx_q   <= idx_q + 3'd1;
      count_q <= count_q + 3'd1;
      if (is_last) begin
        state_q <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_burst_word_serializer.sv
// tb_burst_word_serializer
// Directed test of burst_word_serializer. Expected words are derived from the
// test line pattern (word k = base + k) and the build's start-index rule.

module tb_burst_word_serializer;

  logic         clk;
  logic         reset;
  logic [127:0] line_in;
  logic [3:0]   offset;
  logic         single;
  logic         load_valid;
  logic         load_ready;
  logic         abort;
  logic [15:0]  word_out;
  logic         word_valid;
  logic         word_ready;
  logic [2:0]   word_index;
  logic         last;
  logic         busy;

  int num_checks = 0;
  int num_fail   = 0;

  burst_word_serializer #(.WORDS(8), .WORD_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .line_in    (line_in),
    .offset     (offset),
    .single     (single),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .abort      (abort),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_index (word_index),
    .last       (last),
    .busy       (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] makeLine(input logic [15:0] base);
    logic [127:0] l;
    for (int k = 0; k < 8; k++) l[16*k +: 16] = base + 16'(k);
    return l;
  endfunction

  // Expected first word of a full (non-single) burst for this build.
  function automatic logic [2:0] startOf(input logic [3:0] off);
`ifdef BURST_SERIALIZER_CRITICAL_FIRST_EN
    return off[3:1];
`else
    return (off == 4'h0) ? 3'd0 : 3'd0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    assert (observed === expected) else begin
      num_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".valid"}, 32'(word_valid), 32'd0);
    checkOutput({tag, ".busy"},  32'(busy),       32'd0);
    checkOutput({tag, ".last"},  32'(last),       32'd0);
    checkOutput({tag, ".word"},  32'(word_out),   32'd0);
  endtask

  task automatic checkBeat(input string tag, input logic [15:0] base,
                           input logic [2:0] idx, input logic exp_last);
    checkOutput({tag, ".valid"}, 32'(word_valid), 32'd1);
    checkOutput({tag, ".word"},  32'(word_out),   32'(base + 16'(idx)));
    checkOutput({tag, ".index"}, 32'(word_index), 32'(idx));
    checkOutput({tag, ".last"},  32'(last),       32'(exp_last));
  endtask

  // Present one line and take it on the next edge.
  task automatic applyStimulus(input logic [15:0] base, input logic [3:0] off,
                               input logic sgl);
    line_in    = makeLine(base);
    offset     = off;
    single     = sgl;
    load_valid = 1'b1;
    #1;
    checkOutput("load.ready", 32'(load_ready), 32'd1);
    step();
    load_valid = 1'b0;
  endtask

  initial begin
    logic [2:0] st;
    int         got;
    int         cyc;
    bit         pat [4];

    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    reset = 1'b1; line_in = '0; offset = 4'h0; single = 1'b0;
    load_valid = 1'b0; abort = 1'b0; word_ready = 1'b0;
    #2;
    // Reset values
    checkIdle("reset");
    checkOutput("reset.index", 32'(word_index), 32'd0);
    checkOutput("reset.ready", 32'(load_ready), 32'd1);
    step();
    reset = 1'b0;
    step();

    // Full burst from offset A, consumer always ready
    $display("[TB] wrap burst");
    word_ready = 1'b1;
    applyStimulus(16'h1000, 4'hA, 1'b0);
    st = startOf(4'hA);
    for (int i = 0; i < 8; i++) begin
      checkBeat("wrap", 16'h1000, 3'(st + 3'(i)), i == 7);
      checkOutput("wrap.noload", 32'(load_ready), 32'(i == 7));
      step();
    end
    checkIdle("wrap.end");

    // Backpressure with ready pattern 1,0,0,1
    $display("[TB] backpressure");
    applyStimulus(16'h1000, 4'h0, 1'b0);
    got = 0;
    cyc = 0;
    while (got < 8 && cyc < 64) begin
      word_ready = pat[cyc % 4];
      #1;
      checkBeat("bp", 16'h1000, 3'(got), got == 7);
      step();
      if (pat[cyc % 4]) got++;
      cyc++;
    end
    checkOutput("bp.beats", 32'(got), 32'd8);
    checkIdle("bp.end");
    word_ready = 1'b1;

    // Single-word read
    $display("[TB] single");
    applyStimulus(16'h1000, 4'h6, 1'b1);
    checkBeat("single", 16'h1000, 3'd3, 1'b1);
    step();
    checkIdle("single.end");
    step();
    checkIdle("single.stay");

    // Back-to-back bursts chained on the last beat
    $display("[TB] back-to-back");
    applyStimulus(16'h1000, 4'h0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      checkBeat("b2b.first", 16'h1000, 3'(i), 1'b0);
      step();
    end
    checkBeat("b2b.lastbeat", 16'h1000, 3'd7, 1'b1);
    line_in    = makeLine(16'h2000);
    offset     = 4'h0;
    single     = 1'b0;
    load_valid = 1'b1;
    #1;
    checkOutput("b2b.ready", 32'(load_ready), 32'd1);
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkBeat("b2b.second", 16'h2000, 3'(i), i == 7);
      step();
    end
    checkIdle("b2b.end");

    // Abort during the fourth beat with a competing load
    $display("[TB] abort");
    applyStimulus(16'h1000, 4'h2, 1'b0);
    st = startOf(4'h2);
    for (int i = 0; i < 3; i++) begin
      checkBeat("abort.pre", 16'h1000, 3'(st + 3'(i)), 1'b0);
      step();
    end
    checkBeat("abort.beat4", 16'h1000, 3'(st + 3'd3), 1'b0);
    abort      = 1'b1;
    line_in    = makeLine(16'h2000);
    load_valid = 1'b1;
    #1;
    checkOutput("abort.ready", 32'(load_ready), 32'd0);
    step();
    abort      = 1'b0;
    load_valid = 1'b0;
    checkIdle("abort.idle");
    step();
    checkIdle("abort.noload");
    applyStimulus(16'h2000, 4'hE, 1'b0);
    st = startOf(4'hE);
    for (int i = 0; i < 8; i++) begin
      checkBeat("abort.reload", 16'h2000, 3'(st + 3'(i)), i == 7);
      step();
    end
    checkIdle("abort.reload.end");

    // Asynchronous reset after three beats
    $display("[TB] mid-burst reset");
    applyStimulus(16'h1000, 4'h0, 1'b0);
    step();
    step();
    step();
    checkBeat("rst.pre", 16'h1000, 3'd3, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkIdle("rst.async");
    checkOutput("rst.ready", 32'(load_ready), 32'd1);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkIdle("rst.after");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
